// File: rtl/mult8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mult8_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Left shift applied to each quadrant's partial product.
    localparam logic [3:0] SHIFT_Q0 = 4'd0;
    localparam logic [3:0] SHIFT_Q1 = 4'd4;
    localparam logic [3:0] SHIFT_Q2 = 4'd4;
    localparam logic [3:0] SHIFT_Q3 = 4'd8;

    // Partial-product combine modes.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    function automatic logic [3:0] f_quad_shift(input logic [1:0] q);
        logic [3:0] sh;
        case (q)
            2'd0:    sh = SHIFT_Q0;
            2'd1:    sh = SHIFT_Q1;
            2'd2:    sh = SHIFT_Q2;
            default: sh = SHIFT_Q3;
        endcase
        return sh;
    endfunction

    // Lowest quadrant index >= start that is not skipped.
    // Returns {found, index}; found = 0 when no such quadrant exists.
    function automatic logic [2:0] f_next_quad(input logic [3:0] skip, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int j = 3; j >= 0; j--) begin
            if ((j >= int'(start)) && !skip[j]) begin
                res = {1'b1, 2'(j)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult8_quad_mux.sv
// Quadrant selector: picks the A/B nibbles and shift for a quadrant, flags skippable quadrants.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mult8_quad_mux
    import mult8_seq_pkg::*;
#(
    parameter int SKIP_ZERO = 1
) (
    input  logic [1:0] i_q,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [3:0] o_nib_a,
    output logic [3:0] o_nib_b,
    output logic [3:0] o_shift,
    output logic [3:0] o_skip
);

    // q[1] selects the A nibble, q[0] selects the B nibble: q0=lo*lo, q1=lo*hi, q2=hi*lo, q3=hi*hi.
    always_comb begin
        o_nib_a = i_q[1] ? i_a[7:4] : i_a[3:0];
        o_nib_b = i_q[0] ? i_b[7:4] : i_b[3:0];
        o_shift = f_quad_shift(i_q);
    end

    // A quadrant with a zero nibble contributes nothing, so it may be skipped when enabled.
    always_comb begin
        o_skip = 4'b0000;
        for (int q = 0; q < 4; q++) begin
            o_skip[q] = (SKIP_ZERO != 0) &&
                        (((q[1] ? i_a[7:4] : i_a[3:0]) == 4'd0) ||
                         ((q[0] ? i_b[7:4] : i_b[3:0]) == 4'd0));
        end
    end

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Builds an 8x8 product from up to four 4x4 partial products on one shared external 4x4 unit.
// Latency: k+1 cycles from accept to out_valid (k = non-skipped quadrants, 0..4).
// Backpressure: single operation in flight; in_ready low until the cycle after the output handshake.
module mult_8x8_seq_ctrl
    import mult8_seq_pkg::*;
#(
    parameter int SKIP_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_or,
    output logic        sub_en,
    output logic [3:0]  sub_a,
    output logic [3:0]  sub_b,
    output logic [1:0]  sub_q,
    input  logic [7:0]  sub_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_r,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_q;
    logic [1:0]  w_q_nxt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_or;
    logic [15:0] r_acc;

    logic        w_accept;
    logic [7:0]  w_op_a;
    logic [7:0]  w_op_b;
    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [3:0]  w_shift;
    logic [3:0]  w_skip;
    logic [2:0]  w_first;
    logic [2:0]  w_next;
    logic [15:0] w_term;

    assign w_accept = in_valid && (r_state == ST_IDLE);

    // In IDLE the skip mask is evaluated on the incoming operands so the first quadrant
    // can be chosen at accept; afterwards it follows the captured operands.
    assign w_op_a = (r_state == ST_IDLE) ? in_a : r_a;
    assign w_op_b = (r_state == ST_IDLE) ? in_b : r_b;

    mult8_quad_mux #(
        .SKIP_ZERO (SKIP_ZERO)
    ) u_quad_mux (
        .i_q     (r_q),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_nib_a (w_nib_a),
        .o_nib_b (w_nib_b),
        .o_shift (w_shift),
        .o_skip  (w_skip)
    );

    assign w_first = f_next_quad(w_skip, 3'd0);
    assign w_next  = f_next_quad(w_skip, {1'b0, r_q} + 3'd1);
    assign w_term  = {8'h00, sub_r} << w_shift;

    // Next-state and quadrant-pointer selection.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_first[2]) begin
                        w_state_nxt = ST_CALC;
                        w_q_nxt     = w_first[1:0];
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_q_nxt     = 2'd0;
                    end
                end
            end
            ST_CALC: begin
                if (w_next[2]) begin
                    w_q_nxt = w_next[1:0];
                end else begin
                    w_state_nxt = ST_DONE;
                    w_q_nxt     = 2'd0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_q_nxt     = 2'd0;
            end
        endcase
    end

    // State and quadrant pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Operand/mode capture at accept; inputs are ignored for the rest of the operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= 8'h00;
            r_b  <= 8'h00;
            r_or <= MODE_ADD;
        end else if (w_accept) begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_or <= in_or;
        end
    end

    // Accumulator: cleared on accept, merges one shifted partial product per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 16'h0000;
        end else if (w_accept) begin
            r_acc <= 16'h0000;
        end else if (r_state == ST_CALC) begin
            if (r_or == MODE_OR) begin
                r_acc <= r_acc | w_term;
            end else begin
                r_acc <= r_acc + w_term;
            end
        end
    end

    // Port drive: the shared-unit bus is quiet outside CALC.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        sub_en    = (r_state == ST_CALC);
        sub_a     = sub_en ? w_nib_a : 4'd0;
        sub_b     = sub_en ? w_nib_b : 4'd0;
        sub_q     = sub_en ? r_q     : 2'd0;
        out_valid = (r_state == ST_DONE);
        out_r     = r_acc;
        busy      = (r_state != ST_IDLE);
    end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
# mult_8x8_seq_ctrl

Sequencing controller that builds one 8x8 product from four 4x4 partial products, time-sharing a single external 4x4 multiplier over up to four cycles. Partial products are merged with either an exact add or an OR composition, selectable per operation. It gives area-constrained designs a single-unit alternative to the four-instance combinational 8x8 approximate multipliers. The external 4x4 unit can be exact or approximate: the controller exposes the quadrant index so that unit can switch variant per quadrant.

## Interface
- `SKIP_ZERO`, default 1: when 1, skip any quadrant whose A-nibble or B-nibble is zero. A skipped quadrant costs no cycle and contributes 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand request.
- `in_ready` out 1: controller can accept operands.
- `in_a` in 8: multiplicand A.
- `in_b` in 8: multiplier B.
- `in_or` in 1: combine mode, 0 = add, 1 = OR; captured at accept.
- `sub_en` out 1: high in cycles where `sub_r` is sampled.
- `sub_a` out 4: nibble of A to the shared 4x4 unit.
- `sub_b` out 4: nibble of B to the shared 4x4 unit.
- `sub_q` out 2: current quadrant index, usable as variant select.
- `sub_r` in 8: 4x4 result, combinational from `sub_a`/`sub_b`/`sub_q` in the same cycle.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_r` out 16: product.
- `busy` out 1: state is not IDLE.

## Operation
- Quadrants are processed in fixed order:
  - q0 = A[3:0]×B[3:0], shift 0
  - q1 = A[3:0]×B[7:4], shift 4
  - q2 = A[7:4]×B[3:0], shift 4
  - q3 = A[7:4]×B[7:4], shift 8
- Operands and mode are registered on accept (`in_valid && in_ready`). Later changes on the inputs are ignored.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE → CALC on accept, if at least one quadrant is not skipped.
  - IDLE → DONE on accept, if all quadrants are skipped.
  - CALC → DONE after the last non-skipped quadrant. The quadrant pointer advances to the next non-skipped quadrant each cycle.
  - DONE → IDLE on `out_valid && out_ready`.
- Accumulation:
  - Accumulator is 16-bit and cleared on accept.
  - Each CALC cycle does acc = acc + (sub_r << shift) in add mode, or acc = acc | (sub_r << shift) in OR mode.
  - Add wraps modulo 2^16; approximate units can exceed 0xFFFF.
- Port behaviour by state:
  - `in_ready` = (state == IDLE).
  - `sub_en` = (state == CALC).
  - `sub_a`, `sub_b`, `sub_q` are driven from the current quadrant in CALC and are 0 otherwise.
- `out_r` = acc, held stable while `out_valid` is high.
- With `SKIP_ZERO` = 0, all four quadrants are always computed.

## Timing
- Reset values: `in_ready` = 1; `out_valid`, `out_r`, `sub_*` and `busy` = 0; accumulator = 0; state = IDLE.
- Latency: with accept at edge 0 and k non-skipped quadrants, `out_valid` rises after edge k+1.
  - k = 4 gives 5 cycles.
  - k = 0 gives 1 cycle.
- Throughput without skipping: one result per 6 cycles at zero backpressure. Accept is possible in the cycle after the output handshake.
- `in_ready` stays 0 from accept until the cycle after the output handshake. There is no overlap between operations.
- Reset asserted in any state forces the reset values immediately. The in-flight operation is dropped and no partial result appears.

## Structure
- Package `mult8_seq_pkg` holds:
  - the state enum (IDLE, CALC, DONE);
  - the quadrant shift constants {0, 4, 4, 8};
  - the combine-mode constants.
- One sub-module is natural: `mult8_quad_mux`, a combinational block that takes the quadrant index and operands and returns the nibbles, the shift, and a zero/skip flag per quadrant.
- FSM, skip-scan, accumulator and handshake logic live in the top module.

## Test plan
All scenarios use an exact 4x4 model as the external unit unless stated otherwise.
- A=0xFF, B=0xFF, add, SKIP_ZERO=0 → `out_r`=0xFE01, `out_valid` 5 cycles after accept, `sub_q` sequence 0,1,2,3.
- A=0x12, B=0x34 → add mode gives 0x03A8; OR mode gives 0x0368.
- SKIP_ZERO=1, A=0x10, B=0x03 → one CALC cycle with `sub_q`=2, `out_r`=0x0030, `out_valid` 2 cycles after accept. Same run with A=0x00 → DONE after 1 cycle, `out_r`=0.
- External unit forced to `sub_r`=0xFF, add mode → `out_r`=0x1FDF (wrap). In OR mode → 0xFFFF.
- `out_ready` held low 10 cycles in DONE → `out_r` stable, `in_ready`=0; handshake → `in_ready`=1 next cycle, and back-to-back accept works.
- `rst` pulsed while `sub_q`=2 → all outputs 0 and `in_ready`=1 during reset; the next operation after release gives the correct result.
